// File: rtl/inst_fetch_ctrl_pkg.sv
// inst_fetch_ctrl shared definitions:
// FSM state codes, AXI response code and reset fetch address.
package inst_fetch_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;

endpackage

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: owns pc, one AXI-Lite read per word, IF/ID slot.
// Ports: clk/rst, stall/flush/branch redirects, AR+R channel, inst slot.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [ADDR_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  output logic              fetch_err
);

  logic [1:0]        state;
  logic [1:0]        state_n;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_n;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] araddr_n;
  logic [ADDR_W-1:0] ld_inst;
  logic              kill;
  logic              kill_n;
  logic              arvalid_n;
  logic              ld;
  logic              ld_err;
  logic              enter;
  logic              redirect;
  logic              slot_free;
  logic              r_hs;
  logic              bad_resp;

  assign redirect  = flush | branch_flag;
  assign tgt       = flush ? flush_pc : branch_target;
  assign slot_free = !inst_valid || !stall;
  assign bad_resp  = rresp != RESP_OKAY;

  // Killed reads are drained regardless of the slot.
  assign rready = (state == ST_DATA) && (kill || slot_free);
  assign r_hs   = rvalid && rready;

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    kill_n    = kill;
    arvalid_n = arvalid;
    araddr_n  = araddr;
    ld        = 1'b0;
    ld_inst   = rdata;
    ld_err    = 1'b0;
    enter     = 1'b0;
    unique case (1'b1)
      state == ST_IDLE: begin
        enter = 1'b1;
        if (redirect) pc_n = tgt;
      end
      state == ST_ADDR: begin
        if (arvalid) begin
          // AR stays up and unchanged until accepted.
          if (arready) begin
            arvalid_n = 1'b0;
            state_n   = ST_DATA;
          end
          if (redirect) begin
            kill_n = 1'b1;
            pc_n   = tgt;
          end
        end else if (redirect) begin
          pc_n  = tgt;
          enter = 1'b1;
        end else if (pc[1:0] != 2'b00) begin
          if (slot_free) begin
            ld      = 1'b1;
            ld_inst = '0;
            ld_err  = 1'b1;
            state_n = ST_ERR;
          end
        end else begin
          enter = 1'b1;
        end
      end
      state == ST_DATA: begin
        if (r_hs) begin
          kill_n = 1'b0;
          enter  = 1'b1;
          if (redirect) begin
            pc_n = tgt;
          end else if (!kill) begin
            ld      = 1'b1;
            ld_inst = bad_resp ? '0 : rdata;
            ld_err  = bad_resp;
            pc_n    = pc + ADDR_W'(4);
            if (bad_resp) begin
              enter   = 1'b0;
              state_n = ST_ERR;
            end
          end
        end else if (redirect) begin
          kill_n = 1'b1;
          pc_n   = tgt;
        end
      end
      state == ST_ERR: begin
        if (redirect) begin
          pc_n  = tgt;
          enter = 1'b1;
        end
      end
      default: ;
    endcase
    // A misaligned pc enters ADDR without raising arvalid.
    if (enter) begin
      state_n = ST_ADDR;
      if (pc_n[1:0] == 2'b00) begin
        arvalid_n = 1'b1;
        araddr_n  = pc_n;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      kill       <= 1'b0;
      arvalid    <= 1'b0;
      araddr     <= RESET_PC;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
      fetch_err  <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      kill    <= kill_n;
      arvalid <= arvalid_n;
      araddr  <= araddr_n;
      if (redirect) begin
        inst_valid <= 1'b0;
      end else if (ld) begin
        inst_valid <= 1'b1;
        inst       <= ld_inst;
        inst_pc    <= pc;
        fetch_err  <= ld_err;
      end else if (!stall) begin
        inst_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: AXI-Lite slave model returning
// rdata=araddr, scoreboards for delivered words and AR addresses.
module tb_inst_fetch_ctrl;

  typedef struct packed {
    logic        err;
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        fetch_err;

  inst_fetch_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall),
    .flush(flush), .flush_pc(flush_pc),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  exp_t        exp_q[$];
  logic [31:0] ar_q[$];
  int          pop_cyc[$];

  // slave configuration and state
  int          cfg_wait = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  int          wl = 0;
  logic        pend = 1'b0;
  logic [31:0] paddr = '0;
  logic        ar_hs_n = 1'b0;
  logic [31:0] ar_addr_n = '0;
  logic        r_hs_n = 1'b0;
  logic        held = 1'b0;
  logic [31:0] held_addr = '0;
  int          ar_count = 0;

  task automatic chk(input string nm, input logic [95:0] act,
                     input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic e, input logic [31:0] i,
                              input logic [31:0] p);
    exp_t x;
    x.err  = e;
    x.inst = i;
    x.pc   = p;
    return x;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string nm, input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      step(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: timeout with %0d words pending, expected 0",
               nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Slave first (drives values for the coming edge), then monitor.
  initial begin
    arready = 1'b0;
    rvalid  = 1'b0;
    rdata   = '0;
    rresp   = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        arready = 1'b0;
        rvalid  = 1'b0;
        pend    = 1'b0;
        wl      = cfg_wait;
        ar_hs_n = 1'b0;
        r_hs_n  = 1'b0;
        held    = 1'b0;
      end else begin
        if (held) begin
          chk("ar_hold_valid", 96'(arvalid), 96'(1));
          chk("ar_hold_addr", 96'(araddr), 96'(held_addr));
        end
        if (r_hs_n) pend = 1'b0;
        if (ar_hs_n) begin
          pend  = 1'b1;
          paddr = ar_addr_n;
          ar_count++;
          if (ar_q.size() != 0)
            chk("araddr_seq", 96'(ar_addr_n), 96'(ar_q.pop_front()));
        end
        if (arvalid) begin
          if (wl > 0) begin
            arready = 1'b0;
            wl--;
          end else begin
            arready = 1'b1;
          end
        end else begin
          arready = 1'b0;
          wl      = cfg_wait;
        end
        rvalid    = pend;
        rdata     = paddr;
        rresp     = (paddr == err_addr) ? 2'b10 : 2'b00;
        ar_hs_n   = arvalid && arready;
        ar_addr_n = araddr;
        r_hs_n    = rvalid && rready;
        held      = arvalid && !arready;
        held_addr = araddr;
      end
      // monitor
      if (rst && inst_valid) begin
        if (!stall) begin
          if (exp_q.size() != 0) begin
            chk("slot_word", 96'({fetch_err, inst, inst_pc}),
                96'(exp_q.pop_front()));
            pop_cyc.push_back(cyc);
          end
        end else begin
          if (exp_q.size() != 0)
            chk("slot_hold", 96'({fetch_err, inst, inst_pc}),
                96'(exp_q[0]));
          if (rvalid) chk("rready_stall", 96'(rready), 96'(0));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int s;
    int n;
    logic [31:0] a;
    rst = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    flush_pc = '0;
    branch_flag = 1'b0;
    branch_target = '0;

    // reset values
    step(3);
    chk("rst_arvalid", 96'(arvalid), 96'(0));
    chk("rst_araddr", 96'(araddr), 96'(32'hBFC0_0000));
    chk("rst_rready", 96'(rready), 96'(0));
    chk("rst_slot", 96'({inst_valid, fetch_err, inst, inst_pc}), 96'(0));

    // streaming from reset, zero-wait slave
    ar_q.push_back(32'hBFC0_0000);
    ar_q.push_back(32'hBFC0_0004);
    ar_q.push_back(32'hBFC0_0008);
    exp_q.push_back(mk(1'b0, 32'hBFC0_0000, 32'hBFC0_0000));
    exp_q.push_back(mk(1'b0, 32'hBFC0_0004, 32'hBFC0_0004));
    exp_q.push_back(mk(1'b0, 32'hBFC0_0008, 32'hBFC0_0008));
    pop_cyc.delete();
    rst = 1'b1;
    c0 = cyc;
    wait_empty("stream", 40);
    if (pop_cyc.size() == 3) begin
      chk("first_latency", 96'(pop_cyc[0] - c0), 96'(3));
      chk("rate_1", 96'(pop_cyc[1] - pop_cyc[0]), 96'(2));
      chk("rate_2", 96'(pop_cyc[2] - pop_cyc[1]), 96'(2));
    end else begin
      chk("pop_count", 96'(pop_cyc.size()), 96'(3));
    end

    // stall 5 cycles with the slot full
    stall = 1'b1;
    exp_q.push_back(mk(1'b0, 32'hBFC0_000C, 32'hBFC0_000C));
    exp_q.push_back(mk(1'b0, 32'hBFC0_0010, 32'hBFC0_0010));
    exp_q.push_back(mk(1'b0, 32'hBFC0_0014, 32'hBFC0_0014));
    step(5);
    chk("stall_slot_full", 96'(inst_valid), 96'(1));
    stall = 1'b0;
    wait_empty("stall_release", 40);

    // branch while AR waits on arready
    cfg_wait = 3;
    n = 0;
    step(1);
    while (!(arvalid && inst_valid && wl == 3) && n < 40) begin
      step(1);
      n++;
    end
    chk("branch_trigger", 96'(n < 40), 96'(1));
    a = araddr;
    ar_q.push_back(a);
    ar_q.push_back(32'h8000_1000);
    ar_q.push_back(32'h8000_1004);
    stall = 1'b1;
    branch_flag = 1'b1;
    branch_target = 32'h8000_1000;
    step(1);
    branch_flag = 1'b0;
    chk("redirect_clears_valid", 96'(inst_valid), 96'(0));
    chk("ar_kept_valid", 96'(arvalid), 96'(1));
    stall = 1'b0;
    exp_q.push_back(mk(1'b0, 32'h8000_1000, 32'h8000_1000));
    exp_q.push_back(mk(1'b0, 32'h8000_1004, 32'h8000_1004));
    wait_empty("branch_wait", 80);
    chk("ar_q_drained", 96'(ar_q.size()), 96'(0));
    cfg_wait = 0;
    step(6);

    // flush and branch together: flush wins
    flush = 1'b1;
    flush_pc = 32'hBFC0_0380;
    branch_flag = 1'b1;
    branch_target = 32'h8000_2000;
    step(1);
    flush = 1'b0;
    branch_flag = 1'b0;
    exp_q.push_back(mk(1'b0, 32'hBFC0_0380, 32'hBFC0_0380));
    exp_q.push_back(mk(1'b0, 32'hBFC0_0384, 32'hBFC0_0384));
    wait_empty("flush_prio", 40);

    // bus error response
    err_addr = 32'h8000_0010;
    branch_flag = 1'b1;
    branch_target = 32'h8000_0010;
    step(1);
    branch_flag = 1'b0;
    exp_q.push_back(mk(1'b1, 32'h0, 32'h8000_0010));
    wait_empty("bus_err", 40);
    s = ar_count;
    step(8);
    chk("err_no_ar", 96'(ar_count), 96'(s));
    chk("err_arvalid", 96'(arvalid), 96'(0));
    err_addr = 32'hFFFF_FFFF;
    flush = 1'b1;
    flush_pc = 32'h8000_0020;
    step(1);
    flush = 1'b0;
    exp_q.push_back(mk(1'b0, 32'h8000_0020, 32'h8000_0020));
    wait_empty("err_exit", 40);
    chk("err_exit_ar", 96'(ar_count > s), 96'(1));

    // misaligned branch target
    branch_flag = 1'b1;
    branch_target = 32'h8000_0002;
    step(1);
    branch_flag = 1'b0;
    exp_q.push_back(mk(1'b1, 32'h0, 32'h8000_0002));
    wait_empty("misalign", 40);
    s = ar_count;
    step(6);
    chk("misalign_no_ar", 96'(ar_count), 96'(s));
    chk("misalign_arvalid", 96'(arvalid), 96'(0));

    // reset mid-DATA
    stall = 1'b1;
    branch_flag = 1'b1;
    branch_target = 32'h8000_0040;
    step(1);
    branch_flag = 1'b0;
    n = 0;
    while (!(rvalid && !rready && !arvalid) && n < 40) begin
      step(1);
      n++;
    end
    chk("data_trigger", 96'(n < 40), 96'(1));
    #2;
    rst = 1'b0;
    #1;
    chk("arst_arvalid", 96'(arvalid), 96'(0));
    chk("arst_araddr", 96'(araddr), 96'(32'hBFC0_0000));
    chk("arst_rready", 96'(rready), 96'(0));
    chk("arst_slot", 96'({inst_valid, fetch_err, inst, inst_pc}), 96'(0));
    step(2);
    stall = 1'b0;
    ar_q.delete();
    ar_q.push_back(32'hBFC0_0000);
    exp_q.push_back(mk(1'b0, 32'hBFC0_0000, 32'hBFC0_0000));
    rst = 1'b1;
    wait_empty("restart", 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
